// File: rtl/core_dbg_arb_pkg.sv
// core_dbg_arb_pkg: shared state encoding, default widths and index-width helper for the debug APB arbiter
package core_dbg_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;
    localparam int DEF_NREQ    = 2;
    localparam int DEF_AW      = 5;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 256;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/core_dbg_apb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request after ptr wins
module rr_arbiter
    import core_dbg_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          grant,
    output logic                  valid
);
    // scan offsets from far to near so the nearest requester after ptr ends up winning
    always_comb begin
        grant = '0;
        for (int i = N; i >= 1; i--) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (req[j]) grant = N'(1) << j;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/core_dbg_apb_arbiter.sv
// core_dbg_apb_arbiter: round-robin sharing of one debug APB slave port among NREQ requesters
module core_dbg_apb_arbiter
    import core_dbg_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr_rd,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    output logic [NREQ-1:0]        done,
    output logic [DW-1:0]          rdata,
    output logic                   err,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [AW-1:0]          paddr,
    output logic [DW-1:0]          pwdata,
    output logic [DW/8-1:0]        pstrb,
    input  logic                   pready,
    input  logic [DW-1:0]          prdata
);
    localparam int IW = idx_w(NREQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam int SW = DW / 8;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   g;
    logic [IW-1:0]   gi;
    logic [NREQ-1:0] grant;
    logic            gv;
    logic [WW-1:0]   wd;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .valid (gv)
    );

    // one-hot grant to requester index
    always_comb begin
        gi = '0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) gi = IW'(i);
    end

    // transfer FSM: latch winner in IDLE, one SETUP cycle, ACCESS until pready or watchdog expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= IW'(NREQ - 1);
            g       <= '0;
            wd      <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            done    <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (gv) begin
                    g      <= gi;
                    ptr    <= gi;
                    pwrite <= req_wr_rd[gi];
                    paddr  <= req_addr[int'(gi)*AW +: AW];
                    pwdata <= req_wdata[int'(gi)*DW +: DW];
                    pstrb  <= req_wr_rd[gi] ? req_wstrb[int'(gi)*SW +: SW] : '0;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    wd      <= '0;
                    state   <= ACCESS;
                end
                ACCESS: if (pready || wd == WW'(TIMEOUT - 1)) begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    done    <= NREQ'(1) << g;
                    rdata   <= (pready && !pwrite) ? prdata : '0;
                    err     <= !pready;
                    state   <= IDLE;
                end else begin
                    wd <= wd + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
